// File: rtl/fifo_pkg.sv
// Shared constants, FSM encoding and index helper for the FIFO write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int MAX_N = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        logic [IDX_W-1:0] nxt;
        nxt = idx + 1'b1;
        if (int'(idx) >= n - 1) nxt = '0;
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating first-set search: lowest (index - i_ptr) mod N among set request bits.
// Latency: combinational, zero cycles.
// Backpressure: none; o_vld=0 when no request is set.
module fifo_rr_pick
    import fifo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    always_comb begin
        int d;
        int best;
        o_idx = '0;
        o_vld = 1'b0;
        best  = N;
        d     = 0;
        for (int j = 0; j < N; j++) begin
            d = j - int'(i_ptr);
            if (d < 0) d = d + N;
            if (i_req[j] && d < best) begin
                best  = d;
                o_idx = IDX_W'(j);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// N-way round-robin arbiter onto one FIFO write port; burst locking under FIFO_WR_ARB_BURST_EN.
// Latency: zero -- Gnt/Winc/Wdata follow Req combinationally in the same cycle.
// Backpressure: Wfull suppresses Winc/Gnt and freezes pointer, owner, count and state.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                    Wclk,
    input  logic                    Wrst,
    input  logic [N-1:0]            Req,
    input  logic [N*DATA_WIDTH-1:0] Din,
    input  logic                    Wfull,
    output logic                    Winc,
    output logic [DATA_WIDTH-1:0]   Wdata,
    output logic [N-1:0]            Gnt,
    output logic [2:0]              Owner
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_pick_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_vld;
    logic             w_acc;

    fifo_rr_pick #(.N(N)) u_pick (
        .i_req (Req),
        .i_ptr (w_pick_ptr),
        .o_idx (w_idx),
        .o_vld (w_vld)
    );

    // Gating with Wrst keeps the write port quiet while reset is held.
    assign w_acc = w_vld & ~Wfull & Wrst;
    assign Winc  = w_acc;
    assign Owner = r_owner;

    always_comb begin
        Gnt   = '0;
        Wdata = '0;
        for (int j = 0; j < N; j++) begin
            if (w_idx == IDX_W'(j)) begin
                Gnt[j] = w_acc;
                if (w_vld && Wrst) Wdata = Din[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifndef FIFO_WR_ARB_BURST_EN

    assign w_pick_ptr = r_ptr;

    always_ff @(posedge Wclk or negedge Wrst) begin
        if (!Wrst) begin
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (w_acc) begin
            r_ptr   <= wrap_inc(w_idx, N);
            r_owner <= w_idx;
        end
    end

`else

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_own_req;

    always_comb begin
        w_own_req = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (r_owner == IDX_W'(j)) w_own_req = Req[j];
        end
    end

    // While locked the owner wins if still requesting; once it drops, search resumes after it.
    always_comb begin
        w_pick_ptr = r_ptr;
        if (r_state == ST_LOCKED) w_pick_ptr = w_own_req ? r_owner : wrap_inc(r_owner, N);
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        if (w_acc) begin
            if (r_state == ST_IDLE) begin
                if (BURST_MAX > 1) begin
                    w_state_nxt = ST_LOCKED;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_ptr_nxt = wrap_inc(w_idx, N);
                end
            end else if (!w_own_req || int'(w_cnt_inc) >= BURST_MAX) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_ptr_nxt   = wrap_inc(w_idx, N);
            end else begin
                w_cnt_nxt = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge Wclk or negedge Wrst) begin
        if (!Wrst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_acc) r_owner <= w_idx;
        end
    end

`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and scoreboarded checks of fifo_wr_arbiter (N=4, 8-bit words, BURST_MAX=4).
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic            Wclk = 1'b0;
    logic            Wrst;
    logic [N-1:0]    Req;
    logic [N*DW-1:0] Din;
    logic            Wfull;
    logic            Winc;
    logic [DW-1:0]   Wdata;
    logic [N-1:0]    Gnt;
    logic [2:0]      Owner;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [N-1:0]  pend;
    int            m_ptr, m_owner, m_cnt, m_start, m_c;
    bit            m_locked, m_acc;
    logic [N-1:0]  m_gnt;

    fifo_wr_arbiter #(.N(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .Wclk  (Wclk),
        .Wrst  (Wrst),
        .Req   (Req),
        .Din   (Din),
        .Wfull (Wfull),
        .Winc  (Winc),
        .Wdata (Wdata),
        .Gnt   (Gnt),
        .Owner (Owner)
    );

    always #5 Wclk = ~Wclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge Wclk);
        #1;
    endtask

    task automatic do_reset();
        Wrst  = 1'b0;
        Req   = '0;
        Wfull = 1'b0;
        tick();
        tick();
        Wrst = 1'b1;
    endtask

    function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] d, input int i);
        return DW'(d >> (i * DW));
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int start);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (((r >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    initial begin
        Wrst  = 1'b0;
        Req   = '0;
        Wfull = 1'b0;
        Din   = 32'hD3C2B1A0;

        // Outputs held low throughout reset even with every requester asking.
        tick();
        Req = 4'b1111;
        @(negedge Wclk);
        chk("rst_winc", 32'(Winc), 32'd0);
        chk("rst_gnt", 32'(Gnt), 32'd0);
        chk("rst_wdata", 32'(Wdata), 32'd0);
        chk("rst_owner", 32'(Owner), 32'd0);

`ifndef FIFO_WR_ARB_BURST_EN
        do_reset();
        Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge Wclk);
            chk("rr_gnt", 32'(Gnt), 32'd1 << (k % N));
            chk("rr_wdata", 32'(Wdata), 32'(slice(Din, k % N)));
            chk("rr_owner", 32'(Owner), (k == 0) ? 32'd0 : 32'(k - 1));
            tick();
        end

        do_reset();
        Req   = 4'b0101;
        Wfull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Wclk);
            chk("full_winc", 32'(Winc), 32'd0);
            chk("full_gnt", 32'(Gnt), 32'd0);
            tick();
        end
        Wfull = 1'b0;
        @(negedge Wclk);
        chk("unfull_gnt0", 32'(Gnt), 32'h1);
        chk("unfull_wdata0", 32'(Wdata), 32'hA0);
        tick();
        Req = 4'b0100;
        @(negedge Wclk);
        chk("unfull_gnt1", 32'(Gnt), 32'h4);
        chk("unfull_wdata1", 32'(Wdata), 32'hC2);
        tick();
        Req = 4'b0000;
        @(negedge Wclk);
        chk("unfull_owner", 32'(Owner), 32'd2);
        chk("idle_winc", 32'(Winc), 32'd0);
`else
        do_reset();
        Req = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            @(negedge Wclk);
            chk("burst_gnt", 32'(Gnt), (k < 4) ? 32'h1 : 32'h2);
            tick();
        end

        do_reset();
        Req = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            @(negedge Wclk);
            chk("lock_gnt", 32'(Gnt), 32'h1);
            tick();
        end
        Req = 4'b0100;
        @(negedge Wclk);
        chk("drop_gnt", 32'(Gnt), 32'h4);
        tick();
        Req = 4'b0101;
        @(negedge Wclk);
        chk("drop_idle_gnt", 32'(Gnt), 32'h1);
        chk("drop_owner", 32'(Owner), 32'd2);
        tick();
`endif

        // Reset asserted asynchronously in the middle of a stream of writes.
        do_reset();
        Req = 4'b1111;
        tick();
        tick();
        Wrst = 1'b0;
        #1;
        chk("midrst_winc", 32'(Winc), 32'd0);
        chk("midrst_gnt", 32'(Gnt), 32'd0);
        chk("midrst_wdata", 32'(Wdata), 32'd0);
        chk("midrst_owner", 32'(Owner), 32'd0);
        tick();
        Wrst = 1'b1;
        @(negedge Wclk);
        chk("midrst_first_gnt", 32'(Gnt), 32'h1);
        tick();

        // Random traffic against a reference model and a write-order scoreboard.
        do_reset();
        pend     = '0;
        m_ptr    = 0;
        m_owner  = 0;
        m_cnt    = 0;
        m_locked = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int j = 0; j < N; j++) begin
                if (!pend[j] && $urandom_range(0, 1) == 1) pend[j] = 1'b1;
            end
            Req   = pend;
            Wfull = ($urandom_range(0, 9) < 3);
            Din   = $urandom;
            @(negedge Wclk);
            m_start = m_ptr;
            if (m_locked) m_start = pend[m_owner] ? m_owner : (m_owner + 1) % N;
            m_c   = pick(pend, m_start);
            m_acc = (m_c >= 0) && !Wfull;
            m_gnt = m_acc ? N'(1 << m_c) : '0;
            chk("rnd_gnt", 32'(Gnt), 32'(m_gnt));
            chk("rnd_owner", 32'(Owner), 32'(m_owner));
            if (Wfull) chk("rnd_no_write_full", 32'(Winc), 32'd0);
            if (Winc) fifo_q.push_back(Wdata);
            if (m_acc) begin
                exp_q.push_back(slice(Din, m_c));
                pend[m_c] = 1'b0;
`ifndef FIFO_WR_ARB_BURST_EN
                m_ptr = (m_c + 1) % N;
`else
                if (!m_locked) begin
                    if (BM == 1) m_ptr = (m_c + 1) % N;
                    else begin
                        m_locked = 1'b1;
                        m_cnt    = 1;
                    end
                end else if (m_c != m_owner || m_cnt + 1 >= BM) begin
                    m_locked = 1'b0;
                    m_cnt    = 0;
                    m_ptr    = (m_c + 1) % N;
                end else begin
                    m_cnt = m_cnt + 1;
                end
`endif
                m_owner = m_c;
            end
            tick();
        end
        Req   = '0;
        Wfull = 1'b0;
        chk("sb_len", 32'(fifo_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < fifo_q.size() && i < exp_q.size(); i++) begin
            chk("sb_data", 32'(fifo_q[i]), 32'(exp_q[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
